// File: rtl/id_stage.sv
`default_nettype none
// id_stage: instruction decode, 32x32 register file with write-through, branch resolution,
// hazard detection and the ID/EX pipeline register of the 32-bit pipeline.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Next_Address_in,
  input  logic [31:0] Instruction_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  output logic        PCWrite,
  output logic        freeze,
  output logic        flush,
  output logic        PCSrc,
  output logic [31:0] Branch_Address,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic [1:0]  ex_alu_op,
  output logic [31:0] ex_read_data1,
  output logic [31:0] ex_read_data2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_write_reg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
  } idex_t;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;

  assign op      = Instruction_in[31:26];
  assign rs      = Instruction_in[25:21];
  assign rt      = Instruction_in[20:16];
  assign rd      = Instruction_in[15:11];
  assign imm_ext = {{16{Instruction_in[15]}}, Instruction_in[15:0]};

  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_alu_src;
  logic [1:0] dec_alu_op;
  logic [4:0] dec_write_reg;
  logic       is_beq, is_bne, uses_rt;

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = 2'b00;
    dec_write_reg  = 5'd0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    uses_rt        = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
        dec_write_reg = rd;
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 1'b1;
        dec_write_reg  = rt;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_write_reg = rt;
      end
      OP_BEQ: begin
        dec_alu_op = 2'b01;
        is_beq     = 1'b1;
        uses_rt    = 1'b1;
      end
      OP_BNE: begin
        dec_alu_op = 2'b01;
        is_bne     = 1'b1;
        uses_rt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; r0 is never written, so it stays zero after reset.
  logic [31:0] rf_q [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  logic [31:0] rdata1, rdata2;

  always_comb begin
    rdata1 = rf_q[rs];
    rdata2 = rf_q[rt];
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) rdata1 = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) rdata2 = wb_data;
    if (rs == 5'd0) rdata1 = '0;
    if (rt == 5'd0) rdata2 = '0;
  end

  idex_t idex_d, idex_q;

  logic is_branch, load_use, branch_ex, branch_mem, stall, branch_cond, taken;

  assign is_branch  = is_beq | is_bne;
  assign load_use   = idex_q.mem_read && (idex_q.write_reg != 5'd0) &&
                      ((idex_q.write_reg == rs) || (uses_rt && (idex_q.write_reg == rt)));
  assign branch_ex  = is_branch && idex_q.reg_write && (idex_q.write_reg != 5'd0) &&
                      ((idex_q.write_reg == rs) || (idex_q.write_reg == rt));
  assign branch_mem = is_branch && mem_mem_read && (mem_write_reg != 5'd0) &&
                      ((mem_write_reg == rs) || (mem_write_reg == rt));
  assign stall       = load_use | branch_ex | branch_mem;
  assign branch_cond = (is_beq && (rdata1 == rdata2)) || (is_bne && (rdata1 != rdata2));
  assign taken       = ~stall & branch_cond;

  // Reset overrides the hazard/branch controls so IF keeps running cleanly.
  assign PCWrite        = ~rst | ~stall;
  assign freeze         = rst & stall;
  assign flush          = rst & taken;
  assign PCSrc          = rst & taken;
  assign Branch_Address = Next_Address_in + {imm_ext[29:0], 2'b00};

  always_comb begin
    idex_d = '0;
    if (!stall) begin
      idex_d.reg_write  = dec_reg_write;
      idex_d.mem_read   = dec_mem_read;
      idex_d.mem_write  = dec_mem_write;
      idex_d.mem_to_reg = dec_mem_to_reg;
      idex_d.alu_src    = dec_alu_src;
      idex_d.alu_op     = dec_alu_op;
      idex_d.read_data1 = rdata1;
      idex_d.read_data2 = rdata2;
      idex_d.imm        = imm_ext;
      idex_d.rs         = rs;
      idex_d.rt         = rt;
      idex_d.write_reg  = dec_write_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign ex_reg_write  = idex_q.reg_write;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_mem_to_reg = idex_q.mem_to_reg;
  assign ex_alu_src    = idex_q.alu_src;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_read_data1 = idex_q.read_data1;
  assign ex_read_data2 = idex_q.read_data2;
  assign ex_imm        = idex_q.imm;
  assign ex_rs         = idex_q.rs;
  assign ex_rt         = idex_q.rt;
  assign ex_write_reg  = idex_q.write_reg;

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 32-bit pipeline. It sits directly downstream of the IF stage and consumes the IF/ID register outputs (PC+4 and instruction). It holds the 32x32 register file, decodes control, resolves branches, detects hazards, and returns PCWrite / freeze / flush / PCSrc / Branch_Address to IF. It also owns the ID/EX pipeline register.

## Interface
Parameters: none (fixed 32-bit datapath, 32 registers).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- Next_Address_in  in  32  PC+4 from IF/ID
- Instruction_in  in  32  instruction from IF/ID
- wb_en  in  1  writeback enable
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback data
- mem_mem_read  in  1  instruction in MEM is a load
- mem_write_reg  in  5  destination of the instruction in MEM
- PCWrite  out  1  PC update enable to IF
- freeze  out  1  hold IF/ID
- flush  out  1  clear IF/ID
- PCSrc  out  1  1 = select Branch_Address
- Branch_Address  out  32  branch target
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered control
- ex_alu_op  out  2  00 add, 01 sub, 10 use funct
- ex_read_data1, ex_read_data2, ex_imm  out  32 each  registered operands and sign-extended immediate
- ex_rs, ex_rt, ex_write_reg  out  5 each  registered register numbers

## Operation
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]. ex_imm = sign-extended imm; funct is ex_imm[5:0].
- Decode:
  - op 0x00 (R-type): reg_write, alu_op=10, write_reg=rd.
  - 0x23 (lw): reg_write, mem_read, mem_to_reg, alu_src, alu_op=00, write_reg=rt.
  - 0x2B (sw): mem_write, alu_src, alu_op=00.
  - 0x08 (addi): reg_write, alu_src, alu_op=00, write_reg=rt.
  - 0x04 (beq) / 0x05 (bne): alu_op=01, no writes.
  - Any other op: all controls 0 (NOP).
- Instructions that use rt as a source: R-type, sw, beq, bne.
- Register file:
  - r0 reads 0 and is never written.
  - Write at posedge when wb_en and wb_addr≠0.
  - Reads are combinational with write-through: if wb_en, wb_addr≠0 and wb_addr matches the read index, return wb_data.
- Branch: Branch_Address = Next_Address_in + (sext(imm)<<2), modulo 2^32. Taken when beq and rdata1==rdata2, or bne and rdata1≠rdata2 (values after write-through).
- Hazard stall (stall=1) when any of the following holds:
  - Load-use: ex_mem_read and ex_write_reg≠0 and ex_write_reg equals rs, or equals rt where rt is a source.
  - Branch in ID with ex_reg_write, ex_write_reg≠0, and ex_write_reg matching rs or rt.
  - Branch in ID with mem_mem_read, mem_write_reg≠0, and mem_write_reg matching rs or rt.
- Stall response: PCWrite=0, freeze=1, PCSrc=0, flush=0. ID/EX loads a bubble (all control bits 0, data fields don't-care but driven 0).
- No stall, taken branch: PCWrite=1, PCSrc=1, flush=1, freeze=0.
- Otherwise: PCWrite=1, freeze=0, PCSrc=0, flush=0.
- Stall has priority over branch resolution. A stalled branch re-evaluates every cycle.

## Timing
- PCWrite, freeze, flush, PCSrc and Branch_Address are combinational from the current IF/ID contents, ID/EX state and MEM inputs, within the same cycle.
- ID/EX outputs update at posedge, so an instruction's decoded values appear 1 cycle after it is present at the inputs.
- Register-file write happens at the same posedge on which the write-through value is already visible.
- Reset (rst=0, asynchronous, any time including mid-stall):
  - All ID/EX outputs go to 0.
  - All 32 registers clear to 0.
  - While rst=0, outputs are forced to PCWrite=1, freeze=0, flush=0, PCSrc=0; Branch_Address follows its formula.
- A load-use stall lasts exactly 1 cycle.
- A branch dependent on an ALU op in EX stalls 1 cycle.
- A branch dependent on a load in EX stalls 2 cycles: EX hazard, then MEM hazard.

## Test plan
- Reset check: write r5=0x1234, assert rst=0 mid-cycle. Required: ex_* immediately 0, PCWrite=1; after release, reading r5 returns 0.
- Write-through: wb_en=1, wb_addr=3, wb_data=0xDEADBEEF while decoding add r4,r3,r3. Required: next cycle ex_read_data1 = ex_read_data2 = 0xDEADBEEF; writes to r0 are ignored (reads 0).
- Load-use: lw r2,0(r1) followed by add r3,r2,r1. Required: 1 cycle with PCWrite=0, freeze=1 and a bubble in ID/EX (all control 0), then the add issues with ex_rs=2.
- Branch taken: r1=r2=7, beq r1,r2,+3 at Next_Address_in=0x100. Required: same cycle PCSrc=1, flush=1, Branch_Address=0x10C. With the offset set to -1 instead, Branch_Address=0xFC.
- Branch after load: lw r1 then beq r1,r0. Required: 2 stall cycles, then a correct taken/not-taken decision. The same case with bne r1 preceded by addi r1 requires exactly 1 stall cycle.
- Unknown opcode 0x3F and sw r0-source case: the unknown opcode gives all ex control 0 and no stall; sw with rt equal to ex_write_reg of a preceding lw stalls 1 cycle.
